// File: rtl/uart_pkg.sv
// Shared UART definitions: state encodings, frame constants and defaults.
package uart_pkg;

  localparam int unsigned OVERSAMPLE_DEFAULT = 16;
  localparam int unsigned DATA_BITS          = 8;
  localparam logic        STOP_LEVEL         = 1'b1;

  // Receiver states; the encoding is visible on CS for debug.
  typedef enum logic [2:0] {
    RxIdle  = 3'd0,
    RxStart = 3'd1,
    RxData  = 3'd2,
    RxStop  = 3'd3,
    RxBreak = 3'd4
  } rx_state_e;

  // Transmitter states, kept here so both ends of the link share one package.
  typedef enum logic [3:0] {
    TxIdle  = 4'd0,
    TxStart = 4'd1,
    TxData  = 4'd2,
    TxStop  = 4'd3
  } tx_state_e;

endpackage

// File: rtl/uart_sync.sv
// Metastability synchroniser for an asynchronous input; idles (and resets) high.
module uart_sync
  import uart_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clock,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic [SYNC_STAGES-1:0] stages;

  // Shift the raw input through the flop chain; reset to the idle-high level.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      stages <= '1;
    end else begin
      stages <= {stages[SYNC_STAGES-2:0], d};
    end
  end

  assign q = stages[SYNC_STAGES-1];

endmodule

// File: rtl/uart_rx_only.sv
// 8N1 UART receiver with oversample-tick bit timing, a holding register,
// ready/read handshake and framing/overrun status.
// OVERSAMPLE must be an even power of two in 8..64; SYNC_STAGES at least 2.
module uart_rx_only
  import uart_pkg::*;
#(
  parameter int unsigned OVERSAMPLE  = OVERSAMPLE_DEFAULT,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       rxd,
  input  logic       sample,
  input  logic       rd,
  output logic [7:0] dout,
  output logic       ready,
  output logic       frame_err,
  output logic       overrun,
  output logic [2:0] CS
);

  localparam int unsigned TW = $clog2(OVERSAMPLE);
  // Mid start bit: half a bit period after the falling edge was first seen.
  localparam logic [TW-1:0] TICK_MID = TW'(OVERSAMPLE / 2 - 1);
  localparam logic [TW-1:0] TICK_END = TW'(OVERSAMPLE - 1);
  localparam logic [2:0]    LAST_BIT = 3'(DATA_BITS - 1);

  logic            rxd_s;
  rx_state_e       state;
  logic [TW-1:0]   tick_cnt;
  logic [2:0]      bit_cnt;
  logic [7:0]      shreg;

  uart_sync #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync (
    .clock(clock),
    .reset(reset),
    .d    (rxd),
    .q    (rxd_s)
  );

  // Receive FSM with its counters, shift register and registered status outputs.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state     <= RxIdle;
      tick_cnt  <= '0;
      bit_cnt   <= '0;
      shreg     <= '0;
      dout      <= '0;
      ready     <= 1'b0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      // A read clears the status; a completion on the same edge overrides below.
      if (rd && ready) begin
        ready     <= 1'b0;
        frame_err <= 1'b0;
        overrun   <= 1'b0;
      end
      case (state)
        RxIdle: begin
          if (sample && !rxd_s) begin
            state    <= RxStart;
            tick_cnt <= '0;
          end
        end
        RxStart: begin
          if (sample) begin
            if (tick_cnt == TICK_MID) begin
              if (!rxd_s) begin
                state    <= RxData;
                tick_cnt <= '0;
                bit_cnt  <= '0;
              end else begin
                state <= RxIdle;  // glitch, not a real start bit
              end
            end else begin
              tick_cnt <= tick_cnt + 1'b1;
            end
          end
        end
        RxData: begin
          if (sample) begin
            if (tick_cnt == TICK_END) begin
              shreg    <= {rxd_s, shreg[7:1]};
              tick_cnt <= '0;
              bit_cnt  <= bit_cnt + 1'b1;
              if (bit_cnt == LAST_BIT) begin
                state <= RxStop;
              end
            end else begin
              tick_cnt <= tick_cnt + 1'b1;
            end
          end
        end
        RxStop: begin
          if (sample) begin
            if (tick_cnt == TICK_END) begin
              tick_cnt <= '0;
              if (!ready || rd) begin
                dout      <= shreg;
                ready     <= 1'b1;
                frame_err <= (rxd_s != STOP_LEVEL);
                overrun   <= overrun;  // undo the read clear above
              end else begin
                overrun <= 1'b1;
              end
              state <= rxd_s ? RxIdle : RxBreak;
            end else begin
              tick_cnt <= tick_cnt + 1'b1;
            end
          end
        end
        RxBreak: begin
          // Wait for the line to return high so a held-low line never re-triggers.
          if (rxd_s) begin
            state <= RxIdle;
          end
        end
        default: state <= RxIdle;
      endcase
    end
  end

  assign CS = state;

endmodule

// File: tb/tb_uart_rx_only.sv
// Self-checking bench for uart_rx_only: directed scenarios plus randomised bytes
// at nominal and +/-2.5% bit periods, checked against sent-byte expectations.
module tb_uart_rx_only;

  localparam int unsigned OS      = 16;
  localparam int unsigned SYNC    = 2;
  localparam int          BIT_NOM = 160;  // 16 clocks of 10 time units
  // Edges from the start-bit drive to ready: SYNC to reach rxd_s, one to take the
  // falling edge in IDLE, then half a bit plus nine bit periods to mid stop.
  localparam int          EXP_LAT = OS / 2 + 9 * OS + SYNC + 1;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       rxd = 1'b1;
  logic       sample = 1'b1;
  logic       rd = 1'b0;
  logic [7:0] dout;
  logic       ready;
  logic       frame_err;
  logic       overrun;
  logic [2:0] CS;

  int n_checks = 0;
  int n_fail   = 0;

  uart_rx_only #(
    .OVERSAMPLE (OS),
    .SYNC_STAGES(SYNC)
  ) dut (
    .clock    (clock),
    .reset    (reset),
    .rxd      (rxd),
    .sample   (sample),
    .rd       (rd),
    .dout     (dout),
    .ready    (ready),
    .frame_err(frame_err),
    .overrun  (overrun),
    .CS       (CS)
  );

  always #5 clock = ~clock;

  initial begin
    #3000000;
    $display("FAIL watchdog observed=timeout required=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Drive one 8N1 frame LSB-first; start aligned 2 units after a falling clock edge.
  task automatic send_byte(input logic [7:0] data, input logic stop, input int bit_ns);
    @(negedge clock);
    #2 rxd = 1'b0;
    #(bit_ns);
    for (int i = 0; i < 8; i++) begin
      rxd = data[i];
      #(bit_ns);
    end
    rxd = stop;
    #(bit_ns);
    if (stop) rxd = 1'b1;
  endtask

  // Count rising edges after the next falling edge until ready is seen high.
  task automatic wait_ready(input int budget, output int edges);
    @(negedge clock);
    edges = 0;
    while (ready !== 1'b1 && edges < budget) begin
      @(posedge clock);
      #1;
      edges++;
    end
    chk("ready_seen", ready, 1);
  endtask

  task automatic send_wait(input logic [7:0] data, input logic stop, input int bit_ns,
                           output int lat);
    int l;
    fork
      send_byte(data, stop, bit_ns);
      wait_ready(400, l);
    join
    lat = l;
  endtask

  task automatic pulse_rd();
    @(negedge clock);
    rd = 1'b1;
    @(negedge clock);
    rd = 1'b0;
  endtask

  initial begin
    int         lat;
    logic       saw_start;
    logic [7:0] data;
    logic [7:0] junk;
    int         bit_ns;
    logic [7:0] exp_q[$];

    // Reset values
    repeat (3) @(posedge clock);
    @(negedge clock);
    chk("rst_dout", dout, 8'h00);
    chk("rst_ready", ready, 0);
    chk("rst_ferr", frame_err, 0);
    chk("rst_ovr", overrun, 0);
    chk("rst_cs", CS, 0);
    reset = 1'b0;
    repeat (5) @(negedge clock);

    // 1: clean byte with exact latency
    send_wait(8'hA5, 1'b1, BIT_NOM, lat);
    chk("t1_latency", lat, EXP_LAT);
    chk("t1_dout", dout, 8'hA5);
    chk("t1_ferr", frame_err, 0);
    chk("t1_ovr", overrun, 0);
    chk("t1_cs", CS, 0);
    pulse_rd();
    chk("t1_rd_ready", ready, 0);

    // 2: short low pulse is rejected at the start-bit midpoint
    @(negedge clock);
    #2 rxd = 1'b0;
    #50 rxd = 1'b1;
    saw_start = 1'b0;
    repeat (20) begin
      @(posedge clock);
      #1;
      if (CS == 3'd1) saw_start = 1'b1;
    end
    chk("t2_saw_start", saw_start, 1);
    chk("t2_cs", CS, 0);
    chk("t2_ready", ready, 0);
    chk("t2_ferr", frame_err, 0);
    chk("t2_ovr", overrun, 0);

    // 3: low stop bit then held low -> framing error, BREAK until line high
    send_byte(8'h3C, 1'b0, BIT_NOM);
    repeat (40) @(negedge clock);
    chk("t3_dout", dout, 8'h3C);
    chk("t3_ready", ready, 1);
    chk("t3_ferr", frame_err, 1);
    chk("t3_ovr", overrun, 0);
    chk("t3_cs_break", CS, 4);
    rxd = 1'b1;
    repeat (5) @(negedge clock);
    chk("t3_cs_idle", CS, 0);
    pulse_rd();
    chk("t3_rd_ready", ready, 0);
    chk("t3_rd_ferr", frame_err, 0);
    chk("t3_rd_ovr", overrun, 0);

    // 4: back-to-back without read -> first byte kept, overrun set
    send_byte(8'h11, 1'b1, BIT_NOM);
    send_byte(8'h22, 1'b1, BIT_NOM);
    repeat (2) @(negedge clock);
    chk("t4_dout", dout, 8'h11);
    chk("t4_ready", ready, 1);
    chk("t4_ovr", overrun, 1);
    pulse_rd();
    chk("t4_rd_ready", ready, 0);
    chk("t4_rd_ovr", overrun, 0);
    send_wait(8'h33, 1'b1, BIT_NOM, lat);
    chk("t4_dout3", dout, 8'h33);
    chk("t4_ferr3", frame_err, 0);
    chk("t4_ovr3", overrun, 0);
    pulse_rd();

    // 5: read on the exact completion edge while holding a byte
    send_byte(8'h44, 1'b1, BIT_NOM);
    repeat (2) @(negedge clock);
    chk("t5_hold", dout, 8'h44);
    fork
      send_byte(8'h55, 1'b1, BIT_NOM);
      begin
        @(negedge clock);
        repeat (EXP_LAT - 1) @(posedge clock);
        @(negedge clock);
        rd = 1'b1;
        @(posedge clock);
        #1;
        chk("t5_dout", dout, 8'h55);
        chk("t5_ready", ready, 1);
        chk("t5_ovr", overrun, 0);
        @(negedge clock);
        rd = 1'b0;
      end
    join
    chk("t5_ready_after", ready, 1);
    pulse_rd();

    // 6: reset during bit 4 of 0x96; the receiver re-frames from bit 5's falling
    // edge, giving start=b5, data b6,b7 then idle ones; then 0x69 arrives clean.
    data = 8'h96;
    junk = {6'b111111, data[7:6]};
    fork
      send_byte(data, 1'b1, BIT_NOM);
      begin
        @(negedge clock);
        #(2 + BIT_NOM * 5 + 40);
        reset = 1'b1;
        #1;
        chk("t6_rst_cs", CS, 0);
        chk("t6_rst_ready", ready, 0);
        repeat (3) @(posedge clock);
        @(negedge clock);
        reset = 1'b0;
        chk("t6_rst_dout", dout, 8'h00);
      end
    join
    wait_ready(400, lat);
    chk("t6_junk", dout, junk);
    chk("t6_junk_ferr", frame_err, 0);
    pulse_rd();
    repeat (20) @(negedge clock);
    send_wait(8'h69, 1'b1, BIT_NOM, lat);
    chk("t6_dout", dout, 8'h69);
    chk("t6_ferr", frame_err, 0);
    chk("t6_ovr", overrun, 0);
    pulse_rd();

    // Random bytes at nominal and mismatched bit periods
    for (int k = 0; k < 12; k++) begin
      data = 8'($urandom_range(0, 255));
      case ($urandom_range(0, 2))
        0:       bit_ns = 156;
        1:       bit_ns = BIT_NOM;
        default: bit_ns = 164;
      endcase
      repeat ($urandom_range(0, 20)) @(negedge clock);
      exp_q.push_back(data);
      send_wait(data, 1'b1, bit_ns, lat);
      chk("rnd_dout", dout, exp_q.pop_front());
      chk("rnd_ferr", frame_err, 0);
      chk("rnd_ovr", overrun, 0);
      pulse_rd();
      chk("rnd_rd_ready", ready, 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
